prog_mem_loader: RTL and testbench

//  Parametrised TD4 program memory with a built-in nibble-serial loader.
//  - CPU side: combinational fetch of {immediate, opcode} at the PC address.
//  - Host side: streams a program in NIB_W-bit beats over few pins, with an

---
 rtl/td4_pkg.sv | 22 ++
 rtl/prog_mem_loader_if.sv | 28 ++
 rtl/nibble_assembler.sv | 55 +++++
 rtl/prog_mem_loader.sv | 103 ++++++++++
 tb/tb_prog_mem_loader.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/td4_pkg.sv
// Shared types and default sizes for the TD4 program memory and its nibble loader.
package td4_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int OP_W_DEF   = 4;
    localparam int IMM_W_DEF  = 4;
    localparam int NIB_W_DEF  = 4;

    function automatic int cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int BEATS      = (OP_W_DEF + IMM_W_DEF) / NIB_W_DEF;
    localparam int BEAT_CNT_W = cnt_w(BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_e;

endpackage

// File: rtl/prog_mem_loader_if.sv
// Fetch port plus host load stream of the program memory; slave = memory side.
interface prog_mem_loader_if #(
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4,
    parameter int IMM_W  = 4,
    parameter int NIB_W  = 4
);
    logic [ADDR_W-1:0] fetch_addr;
    logic [OP_W-1:0]   opcode_out;
    logic [IMM_W-1:0]  immediate_out;
    logic              load_en;
    logic              load_valid;
    logic [NIB_W-1:0]  load_data;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic              busy;
    logic              load_done;

    modport slave (
        input  fetch_addr, load_en, load_valid, load_data,
        output opcode_out, immediate_out, load_ready, load_addr, busy, load_done
    );

    modport master (
        output fetch_addr, load_en, load_valid, load_data,
        input  opcode_out, immediate_out, load_ready, load_addr, busy, load_done
    );
endinterface

// File: rtl/nibble_assembler.sv
// Collects NIB_W-bit beats LS-chunk first into one word; word_vld_o fires on the final beat
// with the complete word presented combinationally. Latency 0; abort_i clears any partial word.
module nibble_assembler
    import td4_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int NIB_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort_i,
    input  logic              beat_vld_i,
    input  logic [NIB_W-1:0]  beat_dat_i,
    output logic              word_vld_o,
    output logic [WORD_W-1:0] word_dat_o
);
    localparam int NBEATS = WORD_W / NIB_W;
    localparam int CNT_W  = cnt_w(NBEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEATS - 1);

    logic [WORD_W-1:0] shift_q, shift_d, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last;

    always_comb begin
        last   = (cnt_q == LAST);
        word_d = shift_q;
        for (int k = 0; k < NBEATS; k++) begin
            if (cnt_q == CNT_W'(k)) word_d[k*NIB_W +: NIB_W] = beat_dat_i;
        end
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (abort_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (beat_vld_i) begin
            // The finished word goes straight to the array, so the register restarts empty.
            shift_d = last ? '0 : word_d;
            cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign word_vld_o = beat_vld_i && last && !abort_i;
    assign word_dat_o = word_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/prog_mem_loader.sv
// TD4 program memory: combinational {imm, op} fetch plus a nibble-serial host loader.
// Fetch latency 0; one beat per cycle while in LOAD, load_ready low otherwise.
module prog_mem_loader
    import td4_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int IMM_W  = IMM_W_DEF,
    parameter int NIB_W  = NIB_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    prog_mem_loader_if.slave   bus
);
    localparam int WORD_W = OP_W + IMM_W;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] asm_word, rd_word;
    logic              asm_vld, asm_abort, beat_vld, we, ready, done;

    // Dropping load_en wins over a same-cycle beat, so it also aborts the assembler.
    assign asm_abort = (state_q != LOAD) || !bus.load_en;
    assign beat_vld  = (state_q == LOAD) && bus.load_en && bus.load_valid;

    nibble_assembler #(
        .WORD_W (WORD_W),
        .NIB_W  (NIB_W)
    ) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort_i    (asm_abort),
        .beat_vld_i (beat_vld),
        .beat_dat_i (bus.load_data),
        .word_vld_o (asm_vld),
        .word_dat_o (asm_word)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we      = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ptr_d = '0;
                if (bus.load_en) state_d = LOAD;
            end
            LOAD: begin
                ready = 1'b1;
                if (!bus.load_en) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else if (asm_vld) begin
                    we = 1'b1;
                    if (ptr_q == LAST_ADDR) state_d = DONE;
                    else                    ptr_d   = ptr_q + ADDR_W'(1);
                end
            end
            DONE: begin
                done = 1'b1;
                if (!bus.load_en) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[ptr_q] <= asm_word;
        end
    end

    assign rd_word           = mem_q[bus.fetch_addr];
    assign bus.opcode_out    = rd_word[OP_W-1:0];
    assign bus.immediate_out = rd_word[WORD_W-1:OP_W];
    assign bus.load_ready    = ready;
    assign bus.load_done     = done;
    assign bus.busy          = (state_q != IDLE);
    assign bus.load_addr     = done ? LAST_ADDR : ptr_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomised load streams against a behavioural memory/loader model.
module tb_prog_mem_loader;
    localparam int AW = 4, OW = 4, IW = 4, NW = 4;
    localparam int DEPTH = 16, NB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_mem_loader_if #(.ADDR_W(AW), .OP_W(OW), .IMM_W(IW), .NIB_W(NW)) bus ();

    prog_mem_loader #(.ADDR_W(AW), .OP_W(OW), .IMM_W(IW), .NIB_W(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: 0 = idle, 1 = loading, 2 = done
    int         m_mode, m_ptr, m_k, m_beats, dut_beats;
    logic [7:0] m_acc;
    logic [7:0] m_mem [DEPTH];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_k = 0; m_acc = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    task automatic model_edge(input logic en, input logic vld, input logic [3:0] dat);
        case (m_mode)
            0: if (en) begin m_mode = 1; m_ptr = 0; m_k = 0; m_acc = '0; end
            1: begin
                if (!en) begin
                    m_mode = 0; m_ptr = 0; m_k = 0; m_acc = '0;
                end else if (vld) begin
                    m_beats++;
                    m_acc = m_acc | (8'(dat) << (4 * m_k));
                    m_k++;
                    if (m_k == NB) begin
                        m_mem[m_ptr] = m_acc;
                        m_acc = '0;
                        m_k = 0;
                        if (m_ptr == DEPTH - 1) m_mode = 2;
                        else m_ptr++;
                    end
                end
            end
            default: if (!en) begin m_mode = 0; m_ptr = 0; end
        endcase
    endtask

    task automatic check_outputs(input string ph);
        check_val({ph, "_busy"},  32'(bus.busy),       32'(m_mode != 0));
        check_val({ph, "_ready"}, 32'(bus.load_ready), 32'(m_mode == 1));
        check_val({ph, "_done"},  32'(bus.load_done),  32'(m_mode == 2));
        check_val({ph, "_laddr"}, 32'(bus.load_addr),  (m_mode == 2) ? 32'(DEPTH - 1) : 32'(m_ptr));
        check_val({ph, "_fetch"}, 32'({bus.immediate_out, bus.opcode_out}), 32'(m_mem[bus.fetch_addr]));
    endtask

    task automatic check_mem(input string ph);
        bus.load_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.fetch_addr = AW'(i);
            #1;
            check_val($sformatf("%s_word%0d", ph, i), 32'({bus.immediate_out, bus.opcode_out}), 32'(m_mem[i]));
        end
    endtask

    task automatic cycle(input string ph, input logic en, input logic vld, input logic [3:0] dat);
        @(negedge clk);
        bus.load_en    = en;
        bus.load_valid = vld;
        bus.load_data  = dat;
        bus.fetch_addr = AW'($urandom_range(0, DEPTH - 1));
        #1;
        if (bus.load_ready && vld && en) dut_beats++;
        @(posedge clk);
        model_edge(en, vld, dat);
        #1;
        check_outputs(ph);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] saved5;
        bus.load_en = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.fetch_addr = '0;
        m_beats = 0; dut_beats = 0;
        model_reset();
        #2;
        check_outputs("reset");
        check_mem("reset");
        @(negedge clk) rst_n = 1'b1;

        // full load with continuous valid
        cycle("t1", 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < DEPTH * NB; i++) cycle("t1", 1'b1, 1'b1, 4'($urandom));
        check_val("t1_done_after_32", 32'(bus.load_done), 32'd1);
        check_mem("t1");
        cycle("t1", 1'b0, 1'b0, 4'h0);

        // directed word 0 = {A, 3}
        cycle("t2", 1'b1, 1'b0, 4'h0);
        cycle("t2", 1'b1, 1'b1, 4'h3);
        cycle("t2", 1'b1, 1'b1, 4'hA);
        bus.fetch_addr = '0;
        #1;
        check_val("t2_opcode", 32'(bus.opcode_out), 32'h3);
        check_val("t2_imm", 32'(bus.immediate_out), 32'hA);
        check_val("t2_laddr", 32'(bus.load_addr), 32'd1);

        // abort partway through word 5
        for (int i = 0; i < 4 * NB; i++) cycle("t3", 1'b1, 1'b1, 4'($urandom));
        saved5 = m_mem[5];
        cycle("t3", 1'b1, 1'b1, 4'($urandom));
        cycle("t3", 1'b0, 1'b1, 4'($urandom));
        check_mem("t3");
        bus.fetch_addr = 4'd5;
        #1;
        check_val("t3_word5_kept", 32'({bus.immediate_out, bus.opcode_out}), 32'(saved5));
        cycle("t3", 1'b1, 1'b0, 4'h0);
        check_val("t3_reentry_addr", 32'(bus.load_addr), 32'd0);

        // gapped valid until the load completes
        m_beats = 0; dut_beats = 0;
        for (int c = 0; c < 400 && m_mode != 2; c++)
            cycle("t4", 1'b1, 1'($urandom_range(0, 2) != 0), 4'($urandom));
        check_val("t4_beats", 32'(dut_beats), 32'(m_beats));
        check_val("t4_done", 32'(bus.load_done), 32'd1);
        check_mem("t4");

        // beats ignored in DONE
        for (int i = 0; i < 4; i++) cycle("t6", 1'b1, 1'b1, 4'hF);
        check_mem("t6");
        cycle("t6", 1'b0, 1'b1, 4'hF);
        check_val("t6_idle", 32'(bus.busy), 32'd0);

        // async reset in the middle of word 7
        cycle("t5", 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 7 * NB + 1; i++) cycle("t5", 1'b1, 1'b1, 4'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("t5_busy", 32'(bus.busy), 32'd0);
        check_val("t5_ready", 32'(bus.load_ready), 32'd0);
        check_mem("t5");
        @(negedge clk) rst_n = 1'b1;
        bus.load_en = 1'b0;
        cycle("t5_post", 1'b0, 1'b0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
